// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time on a req/gnt/rvalid bus, and feeds the IF/ID register. A one-entry
// hold buffer absorbs a response that returns while IF/ID is stalled. A
// redirect from EX drops any stale fetch that is still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        fetch_flush
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        vld_q, vld_d;
    // Hold buffer occupancy is implied by S_HOLD; leaving HOLD discards it.
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        slot_free;

    // Output register can take a new instruction if IF/ID is consuming or it is empty.
    assign slot_free   = pc_write | ~vld_q;

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = vld_q;
    assign fetch_flush = redirect;

    // Next-state: redirect has top priority, then the per-state fetch handshake.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        vld_d        = vld_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        if (redirect) begin
            pc_d    = redirect_pc & ~32'h0000_0003;
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
            case (state_q)
                // A granted-but-unanswered fetch must be drained before the next request.
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
                S_REQ:   state_d = imem_gnt    ? S_DRAIN : S_REQ;
                S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            // Consumed slot becomes a bubble unless refilled below.
            if (pc_write) begin
                instr_d = NOP_INSTR;
                vld_d   = 1'b0;
            end
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_gnt) begin
                        req_pc_d = pc_q;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = req_pc_q + 32'd4;
                        if (slot_free) begin
                            instr_d  = imem_rdata;
                            pc_out_d = req_pc_q;
                            vld_d    = 1'b1;
                            state_d  = S_REQ;
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = req_pc_q;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (pc_write) begin
                        instr_d  = hold_instr_q;
                        pc_out_d = hold_pc_q;
                        vld_d    = 1'b1;
                        state_d  = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'd0;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= 32'd0;
            vld_q        <= 1'b0;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            vld_q        <= vld_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a reactive instruction memory, a transaction-level
// model (in-flight fetch, stale flag, hold queue, output slot) compared on
// every negedge, and directed scenarios with literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fetch_flush;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out),
        .instr_valid(instr_valid), .fetch_flush(fetch_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hE7, a[23:0]};
    endfunction

    // ---------------- memory responder ----------------
    bit          pend;
    logic [31:0] pend_addr, gnt_addr;
    int          wait_cnt, resp_lat, gnt_hold;

    // Runs just after each posedge: retire last cycle's handshakes, drive this cycle's.
    task automatic mem_drive();
        if (imem_rvalid) pend = 0;
        if (imem_gnt) begin
            pend      = 1;
            pend_addr = gnt_addr;
            wait_cnt  = resp_lat - 1;
        end
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        if (pend) begin
            if (wait_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end else begin
                wait_cnt--;
            end
        end
        if (imem_req && !pend) begin
            if (gnt_hold > 0) gnt_hold--;
            else begin
                imem_gnt = 1'b1;
                gnt_addr = imem_addr;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        mem_drive();
    endtask

    task automatic wait_vld(input string nm);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            cyc();
            n++;
        end
        chk(nm, {31'd0, instr_valid}, 32'd1);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed { logic [31:0] ins; logic [31:0] pc; } pair_t;
    pair_t       holdq[$];
    pair_t       hp;
    bit          m_started, m_infl, m_stale, m_vld, req_now, loaded;
    logic [31:0] m_pc, m_ipc, m_ins, m_pco;

    function automatic bit m_req();
        return m_started && !m_infl && (holdq.size() == 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_started = 0; m_infl = 0; m_stale = 0;
            m_pc = 32'h0; m_ipc = 32'h0;
            m_ins = NOP; m_pco = 32'h0; m_vld = 0;
            holdq.delete();
        end else begin
            req_now = m_req();
            loaded  = 0;
            if (redirect) begin
                if (req_now && imem_gnt) begin m_infl = 1; m_stale = 1; end
                else if (m_infl && imem_rvalid) m_infl = 0;
                else if (m_infl) m_stale = 1;
                m_pc = {redirect_pc[31:2], 2'b00};
                m_ins = NOP; m_vld = 0;
                holdq.delete();
                m_started = 1;
            end else begin
                if (!m_started) m_started = 1;
                else if (req_now && imem_gnt) begin
                    m_infl = 1; m_stale = 0; m_ipc = m_pc;
                end else if (m_infl && imem_rvalid) begin
                    m_infl = 0;
                    if (!m_stale) begin
                        m_pc = m_ipc + 32'd4;
                        if (pc_write || !m_vld) begin
                            m_ins = imem_rdata; m_pco = m_ipc; m_vld = 1; loaded = 1;
                        end else holdq.push_back({imem_rdata, m_ipc});
                    end
                end else if (holdq.size() != 0 && pc_write) begin
                    hp = holdq.pop_front();
                    m_ins = hp.ins; m_pco = hp.pc; m_vld = 1; loaded = 1;
                end
                if (pc_write && !loaded) begin m_ins = NOP; m_vld = 0; end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_req",   {31'd0, imem_req},    {31'd0, m_req()});
        chk("m_addr",  imem_addr,            m_pc);
        chk("m_vld",   {31'd0, instr_valid}, {31'd0, m_vld});
        chk("m_instr", instr_out,            m_ins);
        if (m_vld) chk("m_pcout", pc_out, m_pco);
        chk("m_flush", {31'd0, fetch_flush}, {31'd0, redirect});
    end

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1; pc_write = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pend = 0; pend_addr = 0; gnt_addr = 0; wait_cnt = 0; resp_lat = 1; gnt_hold = 0;
        cyc(); cyc();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_pcout", pc_out, 32'h0);
        reset = 1'b0;

        // Back-to-back fetches with consumption every cycle.
        cyc(); cyc(); cyc();
        chk("f0_vld",   {31'd0, instr_valid}, 32'd1);
        chk("f0_instr", instr_out, 32'hE700_0000);
        chk("f0_pc",    pc_out, 32'h0);
        chk("f0_next",  imem_addr, 32'h4);
        cyc();
        chk("f0_bubble", instr_out, NOP);
        cyc();
        chk("f1_instr", instr_out, 32'hE700_0004);
        chk("f1_pc",    pc_out, 32'h4);
        cyc(); cyc();
        chk("f2_instr", instr_out, 32'hE700_0008);
        chk("f2_next",  imem_addr, 32'hC);

        // Stall five cycles while 0xC returns into the hold buffer.
        pc_write = 1'b0;
        repeat (5) cyc();
        chk("st_instr", instr_out, 32'hE700_0008);
        chk("st_vld",   {31'd0, instr_valid}, 32'd1);
        chk("st_noreq", {31'd0, imem_req}, 32'd0);
        pc_write = 1'b1;
        cyc();
        chk("st_rel_instr", instr_out, 32'hE700_000C);
        chk("st_rel_pc",    pc_out, 32'hC);
        chk("st_rel_addr",  imem_addr, 32'h10);

        // Redirect while WAIT; the pending response must be drained.
        resp_lat = 3;
        cyc();
        redirect = 1'b1; redirect_pc = 32'h103;
        #1 chk("rw_flush", {31'd0, fetch_flush}, 32'd1);
        cyc();
        redirect = 1'b0; resp_lat = 1;
        chk("rw_vld",   {31'd0, instr_valid}, 32'd0);
        chk("rw_instr", instr_out, NOP);
        chk("rw_drain", {31'd0, imem_req}, 32'd0);
        cyc(); cyc();
        chk("rw_req",  {31'd0, imem_req}, 32'd1);
        chk("rw_addr", imem_addr, 32'h100);

        // Redirect coinciding with rvalid while stalled on a valid instruction.
        cyc(); cyc();
        chk("rv_instr", instr_out, 32'hE700_0100);
        pc_write = 1'b0;
        cyc();
        redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect = 1'b0; pc_write = 1'b1;
        chk("rv_req",  {31'd0, imem_req}, 32'd1);
        chk("rv_addr", imem_addr, 32'h200);
        chk("rv_vld",  {31'd0, instr_valid}, 32'd0);
        wait_vld("rv_wait");
        chk("rv_tgt", instr_out, 32'hE700_0200);

        // Redirect while HOLD discards the held instruction.
        pc_write = 1'b0;
        cyc(); cyc();
        chk("rh_noreq", {31'd0, imem_req}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h300;
        cyc();
        redirect = 1'b0; pc_write = 1'b1;
        chk("rh_addr", imem_addr, 32'h300);
        wait_vld("rh_wait");
        chk("rh_instr", instr_out, 32'hE700_0300);
        chk("rh_pc",    pc_out, 32'h300);

        // Grant withheld four cycles: request and address stay put.
        gnt_hold = 4;
        cyc(); cyc();
        pc_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("gw_req",  {31'd0, imem_req}, 32'd1);
            chk("gw_addr", imem_addr, 32'h308);
            cyc();
        end
        resp_lat = 3;
        cyc();

        // Asynchronous reset in WAIT, then a stray response afterwards.
        reset = 1'b1;
        #1;
        chk("ar_req",   {31'd0, imem_req}, 32'd0);
        chk("ar_vld",   {31'd0, instr_valid}, 32'd0);
        chk("ar_instr", instr_out, NOP);
        chk("ar_pc",    pc_out, 32'h0);
        chk("ar_addr",  imem_addr, 32'h0);
        cyc();
        reset = 1'b0; pc_write = 1'b1; resp_lat = 1;
        cyc(); cyc();
        chk("sr_req",  {31'd0, imem_req}, 32'd1);
        chk("sr_addr", imem_addr, 32'h0);
        chk("sr_vld",  {31'd0, instr_valid}, 32'd0);
        wait_vld("sr_wait");
        chk("sr_instr", instr_out, 32'hE700_0000);
        chk("sr_pc",    pc_out, 32'h0);

        // PC wrap; low target bits are forced to zero.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect = 1'b0;
        cyc();
        wait_vld("wr_wait");
        chk("wr_instr", instr_out, 32'hE7FF_FFFC);
        chk("wr_pc",    pc_out, 32'hFFFF_FFFC);
        chk("wr_req",   {31'd0, imem_req}, 32'd1);
        chk("wr_addr",  imem_addr, 32'h0);

        cyc(); cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
